// File: rtl/cq_pkg.sv
// Shared constants and types for the circular-queue controller (cq_ctrl, cq_ptr).
// The optional sticky misuse flag is enabled by defining CQ_ERR_STICKY_EN.
package cq_pkg;

  localparam int CQ_DW    = 16;
  localparam int CQ_AW    = 3;
  localparam int CQ_DEPTH = 8;

  typedef logic [CQ_AW-1:0] cq_ptr_t;
  typedef logic [CQ_AW:0]   cq_cnt_t;
  typedef logic [CQ_DW-1:0] cq_data_t;

  // What the occupancy counter does on the next edge.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2,
    CNT_CLR  = 2'd3
  } cnt_op_e;

endpackage

// File: rtl/cq_ptr.sv
// Wrapping queue pointer: advances on inc, rolls DEPTH-1 -> 0,
// synchronous clear on clr (priority over inc), asynchronous active-high reset.
module cq_ptr
  import cq_pkg::*;
#(
  parameter int AW    = CQ_AW,
  parameter int DEPTH = CQ_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + AW'(1);
    end
  end

endmodule

// File: rtl/cq_ctrl.sv
// Circular-queue controller driving reg_alu's register file as queue storage.
// Define CQ_ERR_STICKY_EN to enable the sticky misuse flag on err.
module cq_ctrl
  import cq_pkg::*;
#(
  parameter int DW    = CQ_DW,
  parameter int AW    = CQ_AW,
  parameter int DEPTH = CQ_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [DW-1:0] push_data,
  output logic          pop_valid,
  input  logic          pop_ready,
  output logic [DW-1:0] pop_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          err,
  output logic          rf_wr,
  output logic          rf_sel,
  output logic [AW-1:0] rf_wr_addr,
  output logic [AW-1:0] rf_rd_addr,
  output logic [DW-1:0] rf_din,
  input  logic [DW-1:0] rf_dout
);

  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic    push_fire;
  logic    pop_fire;
  cnt_op_e cnt_op;

  // Full/empty come from the count because head == tail in both cases.
  assign full       = (count == CNT_FULL);
  assign empty      = (count == '0);
  assign push_ready = ~full;
  assign pop_valid  = ~empty;

  assign push_fire  = push_valid & push_ready;
  assign pop_fire   = pop_valid & pop_ready;

  // Flush suppresses the write so a discarded entry never lands in the file.
  assign rf_wr      = push_fire & ~flush & ~reset;
  assign rf_sel     = 1'b0;
  assign rf_din     = push_data;
  assign pop_data   = rf_dout;

  cq_ptr #(
    .AW   (AW),
    .DEPTH(DEPTH)
  ) u_tail (
    .clk  (clk),
    .reset(reset),
    .clr  (flush),
    .inc  (push_fire),
    .ptr  (rf_wr_addr)
  );

  cq_ptr #(
    .AW   (AW),
    .DEPTH(DEPTH)
  ) u_head (
    .clk  (clk),
    .reset(reset),
    .clr  (flush),
    .inc  (pop_fire),
    .ptr  (rf_rd_addr)
  );

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_op = CNT_HOLD;
    if (flush) begin
      cnt_op = CNT_CLR;
    end else if (push_fire && !pop_fire) begin
      cnt_op = CNT_INC;
    end else if (pop_fire && !push_fire) begin
      cnt_op = CNT_DEC;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      unique case (cnt_op)
        CNT_INC:  count <= count + (AW + 1)'(1);
        CNT_DEC:  count <= count - (AW + 1)'(1);
        CNT_CLR:  count <= '0;
        default:  count <= count;
      endcase
    end
  end

`ifdef CQ_ERR_STICKY_EN
  // Misuse is judged on the offer, not the fire: pushing at full or popping
  // while empty. Only reset clears it; flush leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if ((push_valid && full) || (pop_ready && empty)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
